// File: rtl/multiplier_simd_mac_pipe_pkg.sv
// Shared definitions for the SIMD multiply-accumulate pipeline: mode encodings
// and parameter helpers.
package multiplier_simd_pkg;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_SUM8 = 2'b01,
    MODE_SUM4 = 2'b10,
    MODE_SUM2 = 2'b11
  } mode_t;

  // Widest lane used by the lane-sum modes.
  localparam int unsigned MAX_LANE_W = 8;

  function automatic int unsigned acc_w_default(input int unsigned w);
    return 2 * w + 8;
  endfunction

  // Lane width for the lane-sum modes; MODE_FULL is handled separately.
  function automatic int unsigned lane_width(input mode_t m);
    case (m)
      MODE_SUM4: return 4;
      MODE_SUM2: return 2;
      default:   return MAX_LANE_W;
    endcase
  endfunction

endpackage

// File: rtl/multiplier_simd_mac_pipe_lane_dot.sv
// Combinational S2 datapath: full WxW product or sum of per-lane products,
// each extended to the accumulator width.
module simd_lane_dot
  import multiplier_simd_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = acc_w_default(W)
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             a_sign,
  input  logic             b_sign,
  input  mode_t            mode,
  output logic [ACC_W-1:0] product
);

  // Lane value widened to 9 bits: zero- or sign-extended from bit l-1.
  function automatic logic signed [MAX_LANE_W:0] lane_ext(
    input logic [MAX_LANE_W-1:0] v,
    input int unsigned           l,
    input logic                  s
  );
    logic [MAX_LANE_W:0] m;
    logic [MAX_LANE_W:0] r;
    m = (9'd1 << l) - 9'd1;
    r = ({1'b0, v} & m) | ((s & v[l-1]) ? ~m : '0);
    return $signed(r);
  endfunction

  logic signed [W:0]       full_a;
  logic signed [W:0]       full_b;
  logic signed [2*W+1:0]   full_p;
  logic [ACC_W-1:0]        full_ext;
  logic [ACC_W-1:0]        lane_sum;
  logic [W-1:0]            sh_a;
  logic [W-1:0]            sh_b;
  logic signed [2*MAX_LANE_W+1:0] lane_p;
  int unsigned             lw;

  // One extra bit per operand lets a single signed multiply cover all sign mixes.
  assign full_a = {a_sign & a[W-1], a};
  assign full_b = {b_sign & b[W-1], b};
  assign full_p = full_a * full_b;

  assign full_ext = (a_sign | b_sign)
                  ? {{(ACC_W-2*W){full_p[2*W-1]}}, full_p[2*W-1:0]}
                  : {{(ACC_W-2*W){1'b0}}, full_p[2*W-1:0]};

  always_comb begin
    lane_sum = '0;
    sh_a     = '0;
    sh_b     = '0;
    lane_p   = '0;
    lw       = lane_width(mode);
    for (int unsigned i = 0; i < W / 2; i++) begin
      if (i < W / lw) begin
        sh_a     = a >> (i * lw);
        sh_b     = b >> (i * lw);
        lane_p   = lane_ext(sh_a[MAX_LANE_W-1:0], lw, a_sign)
                 * lane_ext(sh_b[MAX_LANE_W-1:0], lw, b_sign);
        lane_sum = lane_sum
                 + {{(ACC_W-2*MAX_LANE_W-2){lane_p[2*MAX_LANE_W+1]}}, lane_p};
      end
    end
  end

  assign product = (mode == MODE_FULL) ? full_ext : lane_sum;

endmodule

// File: rtl/multiplier_simd_mac_pipe.sv
// Three-stage SIMD multiply-accumulate: operand register, lane-dot product,
// accumulator; whole pipeline stalls together under output backpressure.
module multiplier_simd_mac_pipe
  import multiplier_simd_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = acc_w_default(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [1:0]       mode,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result
);

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic             s1_a_sign;
  logic             s1_b_sign;
  mode_t            s1_mode;
  logic             s1_acc_en;

  logic             s2_valid;
  logic [ACC_W-1:0] s2_prod;
  logic             s2_acc_en;

  logic [ACC_W-1:0] dot;

  assign in_ready = ~out_valid | out_ready;

  simd_lane_dot #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_lane_dot (
    .a       (s1_a),
    .b       (s1_b),
    .a_sign  (s1_a_sign),
    .b_sign  (s1_b_sign),
    .mode    (s1_mode),
    .product (dot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_sign <= 1'b0;
      s1_b_sign <= 1'b0;
      s1_mode   <= MODE_FULL;
      s1_acc_en <= 1'b0;
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_acc_en <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_a_sign <= a_sign;
        s1_b_sign <= b_sign;
        s1_mode   <= mode_t'(mode);
        s1_acc_en <= acc_en;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod   <= dot;
        s2_acc_en <= s1_acc_en;
      end
      // Bubbles leave the accumulator untouched; S3 feeds back its own register.
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= s2_acc_en ? result + s2_prod : s2_prod;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_simd_mac_pipe.sv
// Scoreboard bench for multiplier_simd_mac_pipe: directed vectors plus random
// traffic with backpressure, checked against an arithmetic reference model.
module tb_multiplier_simd_mac_pipe;

  localparam int W     = 16;
  localparam int ACC_W = 40;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             a_sign;
  logic             b_sign;
  logic [1:0]       mode;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;

  multiplier_simd_mac_pipe #(
    .W     (W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .mode      (mode),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ACC_W-1:0] exp_q[$];
  int               tag_q[$];
  logic [ACC_W-1:0] acc_model = '0;
  int               adv_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed or unsigned integer value of an l-bit field starting at pos.
  function automatic longint lane_val(input logic [W-1:0] x, input int pos, input int l, input logic sg);
    longint one = 1;
    longint v;
    v = (longint'(x) >> pos) & ((one << l) - 1);
    if (sg && ((v >> (l - 1)) & 1) != 0) v = v - (one << l);
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y,
                                                   input logic xs, input logic ys, input logic [1:0] m);
    int     l;
    longint s = 0;
    l = (m == 2'd0) ? W : (m == 2'd1) ? 8 : (m == 2'd2) ? 4 : 2;
    for (int i = 0; i < W / l; i++)
      s += lane_val(x, i * l, l, xs) * lane_val(y, i * l, l, ys);
    return s[ACC_W-1:0];
  endfunction

  always @(posedge clk) if (in_ready) adv_cnt <= adv_cnt + 1;

  task automatic drive(input bit iv, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input bit tas, input bit tbs, input logic [1:0] tm, input bit tacc,
                       input bit ordy, input bit has_exp, input logic [ACC_W-1:0] exp_v);
    @(posedge clk);
    #1;
    in_valid  = iv;
    a         = ta;
    b         = tb;
    a_sign    = tas;
    b_sign    = tbs;
    mode      = tm;
    acc_en    = tacc;
    out_ready = ordy;
    @(negedge clk);
    if (rst_n && in_valid && in_ready) begin
      acc_model = (acc_en ? acc_model : '0) + ref_product(a, b, a_sign, b_sign, mode);
      exp_q.push_back(has_exp ? exp_v : acc_model);
      tag_q.push_back(adv_cnt);
    end
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, ordy, 1'b0, '0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    tag_q.delete();
    acc_model = '0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each output handshake, checks hold stability.
  bit               held = 1'b0;
  logic [ACC_W-1:0] held_val;
  logic [ACC_W-1:0] exp_r;
  int               tag_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) check("hold_stable", {23'd0, out_valid, result}, {23'd0, 1'b1, held_val});
      held     = out_valid && !out_ready;
      held_val = result;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(result), 64'hDEAD);
        end else begin
          exp_r = exp_q.pop_front();
          tag_r = tag_q.pop_front();
          check("result", 64'(result), 64'(exp_r));
          check("latency", 64'(adv_cnt - tag_r), 64'd3);
        end
      end
    end
  end

  int wait_cycles;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    a_sign    = 1'b0;
    b_sign    = 1'b0;
    mode      = 2'd0;
    acc_en    = 1'b0;
    out_ready = 1'b1;
    #12;
    check("init_out_valid", 64'(out_valid), 64'd0);
    check("init_result", 64'(result), 64'd0);
    check("init_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors.
    drive(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 40'hFF_FFFF_FFFE);
    drive(1'b1, 16'h0302, 16'h0405, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 40'd22);
    drive(1'b1, 16'hFFFF, 16'h1111, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 40'hFF_FFFF_FFFC);
    drive(1'b1, 16'd3, 16'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 40'd12);
    drive(1'b1, 16'd5, 16'd6, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 40'd42);
    drive(1'b1, 16'd2, 16'd2, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 40'd46);
    repeat (4) idle(1'b1);

    // Three in flight, then five cycles of downstream stall.
    drive(1'b1, 16'd7, 16'd9, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 16'h8081, 16'h7F02, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 16'hA5C3, 16'h3C5A, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    repeat (5) idle(1'b1);

    // Reset with two transactions in flight; next accumulate starts from zero.
    drive(1'b1, 16'd100, 16'd100, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 16'd50, 16'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, '0);
    pulse_reset();
    drive(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 40'd1);
    repeat (4) idle(1'b1);

    // Random traffic with random bubbles and backpressure.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset();
      drive(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) < 7), 1'b0, '0);
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 50) begin
      idle(1'b1);
      wait_cycles++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
